// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Package : bcd_pkg
// Purpose : Shared types and helpers for the BCD <-> binary converters.
//           - state_t       : converter FSM state encoding (IDLE, SHIFT)
//           - BCD_NIBBLE    : width of one BCD digit
//           - is_bcd_digit  : 1 when a nibble holds a legal decimal digit
// Revision: 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_NIBBLE = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_bcd_digit(input logic [BCD_NIBBLE-1:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_nib_sub3.sv
`default_nettype none
// ============================================================================
// Module  : bcd_nib_sub3
// Purpose : Reverse double-dabble digit correction. A nibble that reads 8 or
//           more after the right shift has 3 subtracted from it.
// Ports   : nib_in  [3:0] - nibble after the shift
//           nib_out [3:0] - corrected nibble
// Revision: 1.0 - initial release
// ============================================================================
module bcd_nib_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] nib_in,
  output logic [BCD_NIBBLE-1:0] nib_out
);

  // Inputs are >= 8 whenever the subtraction happens, so the 4-bit result
  // can never borrow.
  assign nib_out = (nib_in >= 4'd8) ? (nib_in - 4'd3) : nib_in;

endmodule : bcd_nib_sub3
`default_nettype wire

// File: rtl/bcd2b_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd2b_seq
// Purpose : Sequential BCD-to-binary converter (reverse double dabble). One
//           right shift plus per-digit correction per clock; BW clocks per
//           conversion. Operands containing a digit > 9 are rejected.
// Ports   : clk   - rising-edge clock
//           rst   - asynchronous active-high reset
//           bcd   [4*DIGITS-1:0] - packed BCD operand, MS digit in MSBs
//           start - conversion request, sampled while idle
//           busy  - conversion in progress
//           done  - one-cycle pulse: result or error available
//           err   - last accepted operand had an illegal digit
//           bin   [BW-1:0] - binary result of the last completed conversion
// Revision: 1.0 - initial release
// ============================================================================
module bcd2b_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BW     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BCD_NIBBLE*DIGITS-1:0] bcd,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [BW-1:0]                bin
);

  localparam int BCDW = BCD_NIBBLE * DIGITS;
  localparam int SRW  = BCDW + BW;
  localparam int CW   = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);
  localparam longint MAX_DEC = (longint'(10) ** DIGITS) - 1;

  // The binary field must hold the largest DIGITS-digit decimal value.
  if ((64'd1 << BW) <= MAX_DEC) begin : g_bw_check
    $error("bcd2b_seq: BW too small for DIGITS");
  end

  state_t          state, state_next;
  logic [SRW-1:0]  sr;
  logic [SRW-1:0]  shifted;
  logic [BCDW-1:0] bcd_corr;
  logic [SRW-1:0]  corrected;
  logic [CW-1:0]   cnt;
  logic            bcd_valid;
  logic            accept;
  logic            reject;
  logic            last;

  assign shifted = sr >> 1;

  for (genvar d = 0; d < DIGITS; d++) begin : g_sub
    bcd_nib_sub3 u_sub (
      .nib_in  (shifted[BW + BCD_NIBBLE*d +: BCD_NIBBLE]),
      .nib_out (bcd_corr[BCD_NIBBLE*d +: BCD_NIBBLE])
    );
  end

  assign corrected = {bcd_corr, shifted[BW-1:0]};
  assign last      = (cnt == CNT_LAST);

  always_comb begin
    bcd_valid = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (!is_bcd_digit(bcd[BCD_NIBBLE*d +: BCD_NIBBLE])) bcd_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bcd_valid) begin
            accept     = 1'b1;
            state_next = SHIFT;
          end else begin
            reject     = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      bin  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sr   <= {bcd, {BW{1'b0}}};
        cnt  <= '0;
        err  <= 1'b0;
        busy <= 1'b1;
      end else if (reject) begin
        err  <= 1'b1;
        bin  <= '0;
        done <= 1'b1;
      end else if (state == SHIFT) begin
        sr  <= corrected;
        cnt <= cnt + CW'(1);
        if (last) begin
          // Every BCD weight has been moved into the binary field by now.
          assert (corrected[SRW-1:BW] == '0);
          bin  <= corrected[BW-1:0];
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule : bcd2b_seq
`default_nettype wire
